// File: rtl/airlock_sequencer_if.sv
// Signal bundle between the airlock sequencer and its surroundings
// (operator requests, door sensors, counter handshake, actuators).
interface airlock_sequencer_if;
   logic       evac_req;
   logic       fill_req;
   logic       inner_open;
   logic       outer_open;
   logic       timer_done;
   logic       fault_clr;
   logic       timer_start;
   logic [9:0] timer_seconds;
   logic       inner_door_en;
   logic       outer_door_en;
   logic       pump_on;
   logic       vent_on;
   logic       fault;

   modport master (
      output evac_req, fill_req, inner_open, outer_open, timer_done, fault_clr,
      input  timer_start, timer_seconds, inner_door_en, outer_door_en,
             pump_on, vent_on, fault
   );

   modport slave (
      input  evac_req, fill_req, inner_open, outer_open, timer_done, fault_clr,
      output timer_start, timer_seconds, inner_door_en, outer_door_en,
             pump_on, vent_on, fault
   );
endinterface

// File: rtl/airlock_sequencer.sv
// Two-door airlock control FSM: door interlock, pump/vent drive and
// timed-phase handshake with the downstream counter.
module airlock_sequencer #(
   parameter logic [9:0] EVAC_SECONDS = 10'd8,
   parameter logic [9:0] FILL_SECONDS = 10'd7
) (
   input logic               clk,
   input logic               reset,
   airlock_sequencer_if.slave bus
);

   typedef enum logic [2:0] {PRESS, EVAC, VAC, FILL, FAULT} state_t;

   state_t     state, state_nxt;
   logic       start_q, start_nxt;
   logic [9:0] secs_q, secs_nxt;
   logic       inner_q, outer_q, pump_q, vent_q, fault_q;
   logic       closed, done_live;

   assign closed    = !bus.inner_open && !bus.outer_open;
   // start_q marks the entry cycle; a done seen then is stale from the last run
   assign done_live = bus.timer_done && !start_q;

   always_comb begin
      state_nxt = state;
      case (state)
         PRESS: if (bus.evac_req && closed) state_nxt = EVAC;
         EVAC: begin
            if (!closed)        state_nxt = FAULT;
            else if (done_live) state_nxt = VAC;
         end
         VAC:   if (bus.fill_req && closed) state_nxt = FILL;
         FILL: begin
            if (!closed)        state_nxt = FAULT;
            else if (done_live) state_nxt = PRESS;
         end
         FAULT: if (bus.fault_clr && closed) state_nxt = FILL;
         default: state_nxt = PRESS;
      endcase

      start_nxt = (state_nxt != state) && (state_nxt == EVAC || state_nxt == FILL);
      secs_nxt  = 10'd0;
      if (state_nxt == EVAC) secs_nxt = EVAC_SECONDS;
      if (state_nxt == FILL) secs_nxt = FILL_SECONDS;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= PRESS;
         start_q <= 1'b0;
         secs_q  <= 10'd0;
         inner_q <= 1'b1;
         outer_q <= 1'b0;
         pump_q  <= 1'b0;
         vent_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_q <= start_nxt;
         secs_q  <= secs_nxt;
         inner_q <= (state_nxt == PRESS);
         outer_q <= (state_nxt == VAC);
         pump_q  <= (state_nxt == EVAC);
         vent_q  <= (state_nxt == FILL);
         fault_q <= (state_nxt == FAULT);
      end
   end

   assign bus.timer_start   = start_q;
   assign bus.timer_seconds = secs_q;
   assign bus.inner_door_en = inner_q;
   assign bus.outer_door_en = outer_q;
   assign bus.pump_on       = pump_q;
   assign bus.vent_on       = vent_q;
   assign bus.fault         = fault_q;

endmodule
